// File: rtl/axiom_apb_completer_regbank.sv
// APB4 completer with a bank of NUM_REGS 32-bit registers.
// Register 0 is a read-only ID word. Registers 1..NUM_REGS-1 are read/write
// with byte strobes. Every transfer takes WAIT_STATES+1 ACCESS cycles.
// All bus outputs are registered.
module axiom_apb_completer_regbank #(
   parameter int          ADDR_WIDTH  = 32,
   parameter int          DATA_WIDTH  = 32,
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA0B0_0001
) (
   input  logic                           pclk,
   input  logic                           presetn,
   input  logic                           psel,
   input  logic                           penable,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic                           pwrite,
   input  logic [DATA_WIDTH/8-1:0]        pstrb,
   input  logic [2:0]                     pprot,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pready,
   output logic                           pslverr,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int NB = DATA_WIDTH / 8;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACCESS = 1'b1;

   logic [0:0]            state;
   logic [3:0]            wcnt;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // Decode of the live bus, used only on the setup edge.
   logic [7:0]            idx_live;
   logic                  err_live;
   logic [DATA_WIDTH-1:0] rd_live;

   // Transfer attributes captured on the setup edge.
   logic [7:0]            idx_q;
   logic                  wr_q;
   logic                  err_q;
   logic [NB-1:0]         strb_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rd_q;

   logic                  setup;
   logic                  commit;

   // Only pprot[0] (privileged) matters to this block.
   logic                  unused_prot;
   assign unused_prot = ^pprot[2:1];

   assign idx_live = paddr[9:2];
   assign err_live = (paddr[1:0] != 2'b00)
                   || (int'(idx_live) >= NUM_REGS)
                   || (paddr[ADDR_WIDTH-1:10] != '0)
                   || (pwrite && (idx_live == 8'd0))
                   || (pwrite && !pprot[0]);

   assign setup  = (state == S_IDLE) && psel && !penable;
   assign commit = (state == S_ACCESS) && pready && wr_q && !err_q;

   // Read mux over the bank; reg 0 always returns the ID word.
   always_comb begin
      rd_live = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(idx_live) == i) begin
            rd_live = (i == 0) ? ID_VALUE : regs[i];
         end
      end
   end

   // Capture address/data/decode at the setup edge; no reset needed.
   always_ff @(posedge pclk) begin
      if (setup) begin
         idx_q   <= idx_live;
         wr_q    <= pwrite;
         err_q   <= err_live;
         strb_q  <= pstrb;
         wdata_q <= pwdata;
         rd_q    <= (err_live || pwrite) ? '0 : rd_live;
      end
   end

   // Transfer FSM, wait counter and registered response.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state   <= S_IDLE;
         wcnt    <= '0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
      end else begin
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
         if (setup) begin
            state <= S_ACCESS;
            wcnt  <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
               pready  <= 1'b1;
               pslverr <= err_live;
               prdata  <= (err_live || pwrite) ? '0 : rd_live;
            end
         end else if (state == S_ACCESS) begin
            if (pready) begin
               state <= S_IDLE;
            end else if (!psel) begin
               // Master abandoned the transfer: no response, no write.
               state <= S_IDLE;
            end else begin
               wcnt <= wcnt - 4'd1;
               if (wcnt == 4'd1) begin
                  pready  <= 1'b1;
                  pslverr <= err_q;
                  prdata  <= rd_q;
               end
            end
         end
      end
   end

   // Register bank update on the completion edge, with byte-lane strobes.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         if (commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
               if (int'(idx_q) == i) begin
                  wr_pulse[i] <= 1'b1;
                  for (int b = 0; b < NB; b++) begin
                     if (strb_q[b]) begin
                        regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
                     end
                  end
               end
            end
         end
      end
   end

   // Flat export of the bank to SoC logic.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
      if (g == 0) begin : g_id
         assign regs_q[DATA_WIDTH*g +: DATA_WIDTH] = ID_VALUE;
      end else begin : g_rw
         assign regs_q[DATA_WIDTH*g +: DATA_WIDTH] = regs[g];
      end
   end

endmodule

// File: tb/tb_axiom_apb_completer_regbank.sv
// Bench for axiom_apb_completer_regbank: one instance with no wait states,
// one with three, sharing the bus except for psel. A register-array model
// of the bank predicts every response.
module tb_axiom_apb_completer_regbank;

   localparam int          NR = 16;
   localparam logic [31:0] ID = 32'hA0B0_0001;

   logic              pclk = 1'b0;
   logic              presetn;
   logic [1:0]        psel;
   logic              penable;
   logic [31:0]       paddr;
   logic              pwrite;
   logic [3:0]        pstrb;
   logic [2:0]        pprot;
   logic [31:0]       pwdata;
   logic [1:0][31:0]  prdata;
   logic [1:0]        pready;
   logic [1:0]        pslverr;
   logic [1:0][511:0] regs_q;
   logic [1:0][15:0]  wr_pulse;

   int          cmp_cnt = 0;
   int          err_cnt = 0;
   int          ws [2] = '{0, 3};
   logic [31:0] mdl [2][NR];

   always #5 pclk = ~pclk;

   axiom_apb_completer_regbank #(.NUM_REGS(NR), .WAIT_STATES(0)) u_dut0 (
      .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable),
      .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb), .pprot(pprot),
      .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
      .pslverr(pslverr[0]), .regs_q(regs_q[0]), .wr_pulse(wr_pulse[0]));

   axiom_apb_completer_regbank #(.NUM_REGS(NR), .WAIT_STATES(3)) u_dut1 (
      .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable),
      .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb), .pprot(pprot),
      .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
      .pslverr(pslverr[1]), .regs_q(regs_q[1]), .wr_pulse(wr_pulse[1]));

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err(input logic wr, input logic [31:0] a, input logic [2:0] pr);
      return (a % 4 != 0) || (a >= 32'd1024) || ((a >> 2) >= NR)
             || (wr && ((a >> 2) == 0)) || (wr && !pr[0]);
   endfunction

   function automatic logic [511:0] exp_regs(input int d);
      logic [511:0] r;
      r = '0;
      r[31:0] = ID;
      for (int i = 1; i < NR; i++) r[32*i +: 32] = mdl[d][i];
      return r;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NR; i++) mdl[d][i] = '0;
   endtask

   task automatic rst_chk(input int d);
      chk("rst_pready",   512'(pready[d]),   512'(0));
      chk("rst_pslverr",  512'(pslverr[d]),  512'(0));
      chk("rst_prdata",   512'(prdata[d]),   512'(0));
      chk("rst_wr_pulse", 512'(wr_pulse[d]), 512'(0));
      chk("rst_regs_q",   regs_q[d],         exp_regs(d));
   endtask

   task automatic idle(input int n);
      psel = '0;
      penable = 1'b0;
      repeat (n) begin
         @(negedge pclk);
         chk("idle_pready",   512'(pready),   512'(0));
         chk("idle_wr_pulse", 512'(wr_pulse), 512'(0));
      end
   endtask

   // Called at a negedge; returns at the negedge after the completion cycle
   // with psel low, so a following call is a back-to-back transfer.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
      logic        e;
      logic [31:0] er;
      logic [15:0] ep;
      int          idx;
      bit          got;
      idx = int'(addr >> 2);
      e   = model_err(wr, addr, prot);
      er  = '0;
      if (!e && !wr) begin
         if (idx == 0) er = ID;
         else          er = mdl[d][idx];
      end
      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      paddr   = addr;
      pwrite  = wr;
      pstrb   = strb;
      pprot   = prot;
      pwdata  = data;
      @(negedge pclk);
      penable = 1'b1;
      got = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
         if (pready[d]) begin
            got = 1'b1;
            chk("latency", 512'(k),          512'(ws[d] + 1));
            chk("prdata",  512'(prdata[d]),  512'(er));
            chk("pslverr", 512'(pslverr[d]), 512'(e));
         end else begin
            chk("wait_out", 512'({prdata[d], pslverr[d]}), 512'(0));
            @(negedge pclk);
         end
      end
      if (!got) chk("timeout", 512'(pready[d]), 512'(1));
      ep = '0;
      if (wr && !e) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[d][idx][8*b +: 8] = data[8*b +: 8];
         ep[idx] = 1'b1;
      end
      @(negedge pclk);
      chk("wr_pulse",    512'(wr_pulse[d]), 512'(ep));
      chk("regs_q",      regs_q[d],         exp_regs(d));
      chk("pready_once", 512'(pready[d]),   512'(0));
      psel    = '0;
      penable = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          d;
      presetn = 1'b0;
      psel    = '0;
      penable = 1'b0;
      paddr   = '0;
      pwrite  = 1'b0;
      pstrb   = '0;
      pprot   = '0;
      pwdata  = '0;
      model_reset();
      repeat (3) @(negedge pclk);
      rst_chk(0);
      rst_chk(1);
      presetn = 1'b1;
      idle(2);

      // Zero-wait write then read of reg 1.
      xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 3'b001);
      xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
      chk("t1_reg1", 512'(regs_q[0][63:32]), 512'(32'hDEAD_BEEF));

      // Three-wait read of the ID register.
      xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, 3'b001);

      // Byte-strobe merge into reg 2, plus a no-op strobe write.
      xfer(1, 1'b1, 32'h08, 32'h1122_3344, 4'hF, 3'b001);
      xfer(1, 1'b1, 32'h08, 32'hAABB_CCDD, 4'h5, 3'b001);
      xfer(1, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'h0, 3'b011);
      xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001);
      chk("t3_reg2", 512'(regs_q[1][95:64]), 512'(32'h11BB_33DD));
      idle(1);

      // Error cases on both instances.
      for (int i = 0; i < 2; i++) begin
         xfer(i, 1'b0, 32'h40,  32'h0,         4'h0, 3'b001);
         xfer(i, 1'b1, 32'h06,  32'h1234_5678, 4'hF, 3'b001);
         xfer(i, 1'b1, 32'h00,  32'h1234_5678, 4'hF, 3'b001);
         xfer(i, 1'b1, 32'h0C,  32'h1234_5678, 4'hF, 3'b000);
         xfer(i, 1'b0, 32'h404, 32'h0,         4'h0, 3'b001);
      end

      // Abort a write by dropping psel in a wait cycle.
      psel[1] = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1;
      pstrb = 4'hF; pprot = 3'b001; pwdata = 32'hCAFE_F00D;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      chk("abort_wait", 512'(pready[1]), 512'(0));
      idle(6);
      chk("abort_regs", regs_q[1], exp_regs(1));

      // Reset in a wait cycle discards the transfer and clears the bank.
      psel[1] = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      chk("rstmid_wait", 512'(pready[1]), 512'(0));
      presetn = 1'b0;
      @(negedge pclk);
      model_reset();
      rst_chk(0);
      rst_chk(1);
      presetn = 1'b1;
      idle(3);
      xfer(1, 1'b1, 32'h10, 32'h5A5A_0F0F, 4'hF, 3'b111);
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);

      // penable without a setup phase is ignored.
      psel[0] = 1'b1;
      penable = 1'b1;
      repeat (3) begin
         @(negedge pclk);
         chk("no_setup", 512'(pready[0]), 512'(0));
      end
      idle(1);

      // Back-to-back write/read/write.
      xfer(0, 1'b1, 32'h3C, 32'h0BAD_F00D, 4'hF, 3'b001);
      xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b001);
      xfer(0, 1'b1, 32'h3C, 32'h7700_0000, 4'h8, 3'b001);
      xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b001);

      // Randomized traffic against the model.
      for (int n = 0; n < 80; n++) begin
         d = int'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            5:       a = 32'(4 * $urandom_range(16, 255));
            6:       a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            7:       a = 32'(4 * $urandom_range(0, 15)) | (32'($urandom_range(1, 1023)) << 10);
            default: a = 32'(4 * $urandom_range(0, 15));
         endcase
         xfer(d, 1'($urandom), a, $urandom, 4'($urandom), 3'($urandom));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
